seg_frame_decoder: RTL and testbench
====================================

// Module: seg_frame_decoder
// PURPOSE
//  Receive side of the 7-segment display path: reverses the binary->segment encoding applied to each clock field.
//  Accepts a digit-serial frame of 11 segment patterns (time/day/date/month), decodes each to BCD,
//  and assembles binary field values. Range-checks every field and pulses frame_valid or frame_err.
//  Used by the display self-check and by the host-side time loader.
// PARAMETERS
//  NS      60  seconds/minutes modulus (valid field range 0..NS-1)
//  NH      24  hours modulus (0..NH-1)
//  ND       7  days-of-week modulus (0..ND-1)
//  NM      12  months; displayed month valid range 1..NM
//  NDIG    11  digits per frame (fixed order, see BEHAVIOUR)
// PORTS
//  clk          in   1  single clock
//  rst          in   1  synchronous, active-high reset
//  seg_valid    in   1  seg_data/seg_first valid this cycle
//  seg_first    in   1  marks digit 0 of a frame (qualified by seg_valid)
//  seg_data     in   7  segment pattern, bit6..0 = g,f,e,d,c,b,a, active-high
//  seg_ready    out  1  decoder can accept a digit; beat = seg_valid & seg_ready
//  o_hrs        out  7  last good hours, binary
//  o_min        out  7  last good minutes
//  o_sec        out  7  last good seconds
//  o_day        out  3  last good day of week
//  o_date       out  5  last good date as displayed (1..31)
//  o_month      out  4  last good month as displayed (1..12)
//  frame_valid  out  1  one-cycle pulse: good frame latched into o_*
//  frame_err    out  1  one-cycle pulse: frame rejected
//  err_code     out  2  cause, valid with frame_err: 1=bad pattern, 2=range, 3=truncated
// BEHAVIOUR
//  Digit order: H1 H0 M1 M0 S1 S0 D0 T1 T0 N1 N0 (index 0..10). Tens digit first in each pair.
//  Patterns: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex). Pattern 00 (blank) is legal
//   only at tens positions and decodes as 0. Any other pattern is bad.
//  Field value = 10*tens + units. Sizing: 4b x 10 + 4b fits in 7b. Result truncated to the port width
//   only after the range check.
//  FSM: IDLE -> COLLECT -> EMIT -> IDLE.
//   IDLE: seg_ready=1. A beat with seg_first=1 stores digit 0; idx=1; go to COLLECT.
//         Beats with seg_first=0 are accepted and discarded (no error).
//   COLLECT: seg_ready=1. Each beat stores digit idx; idx++.
//     - A beat with seg_first=1: abort with err_code=3 (frame_err pulses next cycle). That beat
//       becomes digit 0 of a new frame; idx=1; stay in COLLECT.
//     - Bad pattern: sets sticky bad flag; collection continues until idx reaches NDIG.
//     - Beat at idx=NDIG-1: go to EMIT.
//   EMIT (1 cycle): seg_ready=0. Range check: hrs<NH, min<NS, sec<NS, day<ND, 1<=date<=31,
//     1<=month<=NM.
//     - All pass and no bad flag: o_* update on this edge; frame_valid=1.
//     - Otherwise: o_* hold; frame_err=1. err_code=1 if bad flag, else 2.
//       Bad pattern takes priority over range.
//  Latency: last beat accepted at edge N -> frame_valid/frame_err high during cycle N+1; o_* valid
//   from N+1. Back-to-back frames: next seg_first accepted at N+2 at the earliest.
//  frame_valid and frame_err are never high together. err_code holds its value until the next frame_err.
//  Reset: state=IDLE; idx=0; bad flag=0; seg_ready=1; o_hrs/o_min/o_sec/o_day=0;
//   o_date=1; o_month=1; frame_valid=0; frame_err=0; err_code=0.
//   Reset mid-frame discards the partial frame and produces no error pulse.
//  seg_valid=0 cycles (gaps) inside a frame are allowed; there is no timeout.
// TESTING
//  1 Frame 23:59:59 day6 date31 month12, no gaps -> frame_valid 1 cycle after 11th beat;
//    o_hrs=23 o_min=59 o_sec=59 o_day=6 o_date=31 o_month=12.
//  2 Same frame with random seg_valid gaps; then a back-to-back second frame 00:00:00 d0 01/01
//    -> two frame_valid pulses; final o_* match the second frame; seg_ready low only in EMIT cycles.
//  3 Units digit of minutes = 7'h7E -> frame_err with err_code=1; o_* keep previous values.
//    Blank (00) at H1 -> accepted, decodes as 0.
//  4 Range: hours 24, then month 00, then date 00 -> three frame_err pulses, each with err_code=2;
//    o_* unchanged.
//  5 seg_first reasserted at idx=5, followed by a full frame -> frame_err with err_code=3,
//    then frame_valid for the restarted frame.
//  6 rst asserted at idx=7, then a full frame -> no pulse from the aborted frame; o_* at reset
//    values (date=1, month=1) until the new frame_valid.

Source files
------------

// File: rtl/seg_frame_decoder.sv
// Decodes an 11-digit 7-segment frame (H1 H0 M1 M0 S1 S0 D0 T1 T0 N1 N0) back into
// binary clock fields, range-checks them and pulses frame_valid or frame_err.
module seg_frame_decoder #(
   parameter int NS   = 60,
   parameter int NH   = 24,
   parameter int ND   = 7,
   parameter int NM   = 12,
   parameter int NDIG = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       seg_valid,
   input  logic       seg_first,
   input  logic [6:0] seg_data,
   output logic       seg_ready,
   output logic [6:0] o_hrs,
   output logic [6:0] o_min,
   output logic [6:0] o_sec,
   output logic [2:0] o_day,
   output logic [4:0] o_date,
   output logic [3:0] o_month,
   output logic       frame_valid,
   output logic       frame_err,
   output logic [1:0] err_code
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      EMIT    = 2'd2
   } state_t;

   localparam logic [3:0] LAST_IDX = 4'(NDIG - 1);
   localparam logic [6:0] NS_W     = 7'(NS);
   localparam logic [6:0] NH_W     = 7'(NH);
   localparam logic [6:0] ND_W     = 7'(ND);
   localparam logic [6:0] NM_W     = 7'(NM);

   // Returns {bad, bcd}; blank is only a legal leading zero on tens positions.
   function automatic logic [4:0] seg_decode(input logic [6:0] pat, input logic tens_pos);
      logic [4:0] r;
      case (pat)
         7'h3F:   r = {1'b0, 4'd0};
         7'h06:   r = {1'b0, 4'd1};
         7'h5B:   r = {1'b0, 4'd2};
         7'h4F:   r = {1'b0, 4'd3};
         7'h66:   r = {1'b0, 4'd4};
         7'h6D:   r = {1'b0, 4'd5};
         7'h7D:   r = {1'b0, 4'd6};
         7'h07:   r = {1'b0, 4'd7};
         7'h7F:   r = {1'b0, 4'd8};
         7'h6F:   r = {1'b0, 4'd9};
         7'h00:   r = {~tens_pos, 4'd0};
         default: r = {1'b1, 4'd0};
      endcase
      return r;
   endfunction

   function automatic logic is_tens_pos(input logic [3:0] i);
      logic t;
      case (i)
         4'd0, 4'd2, 4'd4, 4'd7, 4'd9: t = 1'b1;
         default:                      t = 1'b0;
      endcase
      return t;
   endfunction

   state_t     state_q;
   logic [3:0] idx_q;
   logic [3:0] dig_q [NDIG];
   logic       bad_q;
   logic       seg_ready_q;
   logic       frame_valid_q;
   logic       frame_err_q;
   logic [1:0] err_code_q;
   logic [6:0] hrs_q, min_q, sec_q;
   logic [2:0] day_q;
   logic [4:0] date_q;
   logic [3:0] month_q;

   logic       beat_d;
   logic [3:0] wr_idx_d;
   logic [3:0] bcd_d;
   logic       pat_bad_d;
   logic [6:0] hrs_d, min_d, sec_d, day_d, date_d, month_d;
   logic       range_ok_d;

   // Decode the incoming digit at the position it will occupy.
   always_comb begin
      beat_d   = seg_valid & seg_ready_q;
      wr_idx_d = seg_first ? 4'd0 : idx_q;
      {pat_bad_d, bcd_d} = seg_decode(seg_data, is_tens_pos(wr_idx_d));
   end

   // Fields are assembled at full 7-bit width so out-of-range values are not masked by truncation.
   always_comb begin
      hrs_d      = {3'b000, dig_q[0]} * 7'd10 + {3'b000, dig_q[1]};
      min_d      = {3'b000, dig_q[2]} * 7'd10 + {3'b000, dig_q[3]};
      sec_d      = {3'b000, dig_q[4]} * 7'd10 + {3'b000, dig_q[5]};
      day_d      = {3'b000, dig_q[6]};
      date_d     = {3'b000, dig_q[7]} * 7'd10 + {3'b000, dig_q[8]};
      month_d    = {3'b000, dig_q[9]} * 7'd10 + {3'b000, dig_q[10]};
      range_ok_d = (hrs_d < NH_W) && (min_d < NS_W) && (sec_d < NS_W) && (day_d < ND_W) &&
                   (date_d >= 7'd1) && (date_d <= 7'd31) &&
                   (month_d >= 7'd1) && (month_d <= NM_W);
   end

   // Frame FSM with registered handshake, pulses and field outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         idx_q         <= 4'd0;
         bad_q         <= 1'b0;
         seg_ready_q   <= 1'b1;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         err_code_q    <= 2'd0;
         hrs_q         <= 7'd0;
         min_q         <= 7'd0;
         sec_q         <= 7'd0;
         day_q         <= 3'd0;
         date_q        <= 5'd1;
         month_q       <= 4'd1;
         for (int i = 0; i < NDIG; i++) begin
            dig_q[i] <= 4'd0;
         end
      end else begin
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               seg_ready_q <= 1'b1;
               if (beat_d && seg_first) begin
                  dig_q[0] <= bcd_d;
                  bad_q    <= pat_bad_d;
                  idx_q    <= 4'd1;
                  state_q  <= COLLECT;
               end else begin
                  state_q <= IDLE;
               end
            end
            COLLECT: begin
               seg_ready_q <= 1'b1;
               if (beat_d) begin
                  dig_q[wr_idx_d] <= bcd_d;
                  if (seg_first) begin
                     bad_q       <= pat_bad_d;
                     idx_q       <= 4'd1;
                     frame_err_q <= 1'b1;
                     err_code_q  <= 2'd3;
                  end else if (idx_q == LAST_IDX) begin
                     bad_q       <= bad_q | pat_bad_d;
                     idx_q       <= 4'd0;
                     seg_ready_q <= 1'b0;
                     state_q     <= EMIT;
                  end else begin
                     bad_q <= bad_q | pat_bad_d;
                     idx_q <= idx_q + 4'd1;
                  end
               end else begin
                  state_q <= COLLECT;
               end
            end
            EMIT: begin
               seg_ready_q <= 1'b1;
               state_q     <= IDLE;
               bad_q       <= 1'b0;
               if (!bad_q && range_ok_d) begin
                  hrs_q         <= hrs_d;
                  min_q         <= min_d;
                  sec_q         <= sec_d;
                  day_q         <= day_d[2:0];
                  date_q        <= date_d[4:0];
                  month_q       <= month_d[3:0];
                  frame_valid_q <= 1'b1;
               end else begin
                  frame_err_q <= 1'b1;
                  err_code_q  <= bad_q ? 2'd1 : 2'd2;
               end
            end
            default: begin
               state_q     <= IDLE;
               idx_q       <= 4'd0;
               seg_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign seg_ready   = seg_ready_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign err_code    = err_code_q;
   assign o_hrs       = hrs_q;
   assign o_min       = min_q;
   assign o_sec       = sec_q;
   assign o_day       = day_q;
   assign o_date      = date_q;
   assign o_month     = month_q;

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Directed bench for seg_frame_decoder: good frames, gaps, bad patterns, range errors,
// truncated frames and mid-frame reset, with hand-computed expectations.
module tb_seg_frame_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       seg_valid;
   logic       seg_first;
   logic [6:0] seg_data;
   logic       seg_ready;
   logic [6:0] o_hrs, o_min, o_sec;
   logic [2:0] o_day;
   logic [4:0] o_date;
   logic [3:0] o_month;
   logic       frame_valid, frame_err;
   logic [1:0] err_code;

   int checks   = 0;
   int failures = 0;
   logic [6:0] fr [11];

   seg_frame_decoder dut (
      .clk        (clk),
      .rst        (rst),
      .seg_valid  (seg_valid),
      .seg_first  (seg_first),
      .seg_data   (seg_data),
      .seg_ready  (seg_ready),
      .o_hrs      (o_hrs),
      .o_min      (o_min),
      .o_sec      (o_sec),
      .o_day      (o_day),
      .o_date     (o_date),
      .o_month    (o_month),
      .frame_valid(frame_valid),
      .frame_err  (frame_err),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      logic [6:0] p;
      case (d)
         0: p = 7'h3F;  1: p = 7'h06;  2: p = 7'h5B;  3: p = 7'h4F;  4: p = 7'h66;
         5: p = 7'h6D;  6: p = 7'h7D;  7: p = 7'h07;  8: p = 7'h7F;  9: p = 7'h6F;
         default: p = 7'h00;
      endcase
      return p;
   endfunction

   task automatic build(input int h, input int m, input int s, input int d, input int dt, input int mo);
      fr[0] = seg_of(h / 10);  fr[1]  = seg_of(h % 10);
      fr[2] = seg_of(m / 10);  fr[3]  = seg_of(m % 10);
      fr[4] = seg_of(s / 10);  fr[5]  = seg_of(s % 10);
      fr[6] = seg_of(d);
      fr[7] = seg_of(dt / 10); fr[8]  = seg_of(dt % 10);
      fr[9] = seg_of(mo / 10); fr[10] = seg_of(mo % 10);
   endtask

   // Called on a negedge; the beat is taken on the following posedge.
   task automatic send(input int i, input bit gaps);
      int g;
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      for (int k = 0; k < g; k++) begin
         seg_valid = 1'b0; seg_first = 1'b1; seg_data = 7'h7E;
         @(negedge clk);
         chk("ready_in_gap", seg_ready, 1);
      end
      chk("ready_at_beat", seg_ready, 1);
      seg_valid = 1'b1; seg_data = fr[i]; seg_first = (i == 0);
      @(negedge clk);
      seg_valid = 1'b0; seg_first = 1'b0;
   endtask

   task automatic send_range(input int lo, input int hi, input bit gaps);
      for (int i = lo; i <= hi; i++) send(i, gaps);
   endtask

   task automatic chk_out(input string tag, input int h, input int m, input int s,
                          input int d, input int dt, input int mo);
      chk({tag, ".hrs"},   o_hrs,   h);
      chk({tag, ".min"},   o_min,   m);
      chk({tag, ".sec"},   o_sec,   s);
      chk({tag, ".day"},   o_day,   d);
      chk({tag, ".date"},  o_date,  dt);
      chk({tag, ".month"}, o_month, mo);
   endtask

   // Starts in the EMIT cycle right after the last beat.
   task automatic expect_good(input string tag, input int h, input int m, input int s,
                              input int d, input int dt, input int mo);
      chk({tag, ".ready_emit"}, seg_ready, 0);
      chk({tag, ".early_valid"}, frame_valid, 0);
      @(negedge clk);
      chk({tag, ".valid"}, frame_valid, 1);
      chk({tag, ".err"},   frame_err,   0);
      chk({tag, ".ready_after"}, seg_ready, 1);
      chk_out(tag, h, m, s, d, dt, mo);
   endtask

   task automatic expect_err(input string tag, input int code, input int h, input int m, input int s,
                             input int d, input int dt, input int mo);
      chk({tag, ".ready_emit"}, seg_ready, 0);
      @(negedge clk);
      chk({tag, ".err"},   frame_err,   1);
      chk({tag, ".valid"}, frame_valid, 0);
      chk({tag, ".code"},  err_code,    code);
      chk_out(tag, h, m, s, d, dt, mo);
   endtask

   initial begin
      rst = 1'b1; seg_valid = 1'b0; seg_first = 1'b0; seg_data = 7'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst.ready", seg_ready, 1);
      chk("rst.valid", frame_valid, 0);
      chk("rst.err", frame_err, 0);
      chk("rst.code", err_code, 0);
      chk_out("rst", 0, 0, 0, 0, 1, 1);

      // Non-first beat in IDLE is silently discarded
      seg_data = 7'h7E;
      send(3, 1'b0);
      chk("idle_discard.err", frame_err, 0);
      @(negedge clk);
      chk("idle_discard.err2", frame_err, 0);

      // 1: 23:59:59 day 6, 31/12, no gaps
      build(23, 59, 59, 6, 31, 12);
      send_range(0, 10, 1'b0);
      expect_good("t1", 23, 59, 59, 6, 31, 12);

      // 2: same frame with gaps, then back-to-back second frame
      @(negedge clk);
      send_range(0, 10, 1'b1);
      expect_good("t2a", 23, 59, 59, 6, 31, 12);
      build(0, 0, 0, 0, 1, 1);
      send_range(0, 10, 1'b0);
      expect_good("t2b", 0, 0, 0, 0, 1, 1);

      // 3: blank tens of hours accepted; bad pattern / blank units rejected
      build(9, 34, 56, 3, 15, 7);
      fr[0] = 7'h00;
      send_range(0, 10, 1'b0);
      expect_good("t3_blank", 9, 34, 56, 3, 15, 7);
      build(12, 0, 0, 0, 1, 1);
      fr[3] = 7'h7E;
      send_range(0, 10, 1'b0);
      expect_err("t3_badpat", 1, 9, 34, 56, 3, 15, 7);
      build(24, 0, 0, 0, 1, 1);
      fr[3] = 7'h7E;
      send_range(0, 10, 1'b0);
      expect_err("t3_prio", 1, 9, 34, 56, 3, 15, 7);
      build(1, 2, 3, 4, 5, 6);
      fr[6] = 7'h00;
      send_range(0, 10, 1'b0);
      expect_err("t3_blank_units", 1, 9, 34, 56, 3, 15, 7);

      // 4: range errors
      build(24, 0, 0, 0, 1, 1);
      send_range(0, 10, 1'b0);
      expect_err("t4_hrs24", 2, 9, 34, 56, 3, 15, 7);
      build(1, 1, 1, 1, 1, 0);
      send_range(0, 10, 1'b0);
      expect_err("t4_month0", 2, 9, 34, 56, 3, 15, 7);
      build(1, 1, 1, 1, 0, 1);
      send_range(0, 10, 1'b0);
      expect_err("t4_date0", 2, 9, 34, 56, 3, 15, 7);
      build(1, 1, 1, 7, 1, 1);
      send_range(0, 10, 1'b0);
      expect_err("t4_day7", 2, 9, 34, 56, 3, 15, 7);

      // 5: seg_first at idx 5 truncates, restarted frame completes
      build(17, 8, 42, 5, 28, 2);
      send_range(0, 4, 1'b0);
      send(0, 1'b0);
      chk("t5.err", frame_err, 1);
      chk("t5.code", err_code, 3);
      chk("t5.valid", frame_valid, 0);
      chk_out("t5_hold", 9, 34, 56, 3, 15, 7);
      send_range(1, 10, 1'b0);
      expect_good("t5_restart", 17, 8, 42, 5, 28, 2);

      // 6: reset at idx 7 discards the partial frame
      build(10, 20, 30, 1, 9, 11);
      send_range(0, 6, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6.err", frame_err, 0);
      chk("t6.valid", frame_valid, 0);
      chk("t6.code", err_code, 0);
      chk_out("t6_rst", 0, 0, 0, 0, 1, 1);
      @(negedge clk);
      chk("t6.err2", frame_err, 0);
      send_range(0, 9, 1'b0);
      chk_out("t6_pre", 0, 0, 0, 0, 1, 1);
      send(10, 1'b0);
      expect_good("t6_new", 10, 20, 30, 1, 9, 11);
      @(negedge clk);
      chk("t6.valid_drop", frame_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
